// File: rtl/timer_ctrl.sv
// timer_ctrl: APB register front-end, clock prescaler and control-pulse generator for the 8-bit timer counter.
// Build option: define TIMER_CTRL_WAIT_EN to insert one wait state (WAIT) into every bus access.
module timer_ctrl #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic [DATA_W-1:0] tcnt,
   input  logic              overflow,
   input  logic              underflow,
   output logic              clk_ena,
   output logic [DATA_W-1:0] start_counter,
   output logic              up_down,
   output logic              enable,
   output logic              load,
   output logic              clr_overflow,
   output logic              clr_underflow
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      WAIT   = 2'd2,
      ACCESS = 2'd3
   } bus_state_t;

   localparam logic [ADDR_W-1:0] ADDR_TDR  = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_TCR  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TSR  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_TCNT = ADDR_W'(3);

   bus_state_t        state_reg;
   bus_state_t        state_next;
   logic              access;
   logic              wr_en;
   logic              wr_tdr;
   logic              wr_tcr;
   logic              wr_tsr;
   logic              cks_change;
   logic [DATA_W-1:0] tdr_reg;
   logic              up_down_reg;
   logic              enable_reg;
   logic [1:0]        cks_reg;
   logic [3:0]        presc_reg;
   logic [3:0]        presc_mask;
   logic              load_reg;
   logic              clr_ovf_reg;
   logic              clr_unf_reg;
   logic [DATA_W-1:0] rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ACCESS always falls back to IDLE; IDLE re-enters SETUP on the master's next setup phase,
   // so back-to-back transfers chain with the same timing as a lone transfer.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (psel && !penable) state_next = SETUP;
         SETUP: begin
            if (!psel) begin
               state_next = IDLE;
            end else begin
`ifdef TIMER_CTRL_WAIT_EN
               state_next = WAIT;
`else
               state_next = ACCESS;
`endif
            end
         end
         WAIT:   state_next = psel ? ACCESS : IDLE;
         ACCESS: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign access     = (state_reg == ACCESS);
   assign wr_en      = access & psel & penable & pwrite;
   assign wr_tdr     = wr_en & (paddr == ADDR_TDR);
   assign wr_tcr     = wr_en & (paddr == ADDR_TCR);
   assign wr_tsr     = wr_en & (paddr == ADDR_TSR);
   assign cks_change = wr_tcr & (pwdata[1:0] != cks_reg);

   // Prescaler bit gi participates in the strobe decode when gi <= cks.
   for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign presc_mask[gi] = (2'(gi) <= cks_reg);
   end

   assign clk_ena = &(presc_reg | ~presc_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdr_reg     <= '0;
         up_down_reg <= 1'b0;
         enable_reg  <= 1'b0;
         cks_reg     <= 2'd0;
         presc_reg   <= 4'd0;
         load_reg    <= 1'b0;
         clr_ovf_reg <= 1'b0;
         clr_unf_reg <= 1'b0;
      end else begin
         if (wr_tdr) begin
            tdr_reg <= pwdata;
         end
         if (wr_tcr) begin
            up_down_reg <= pwdata[5];
            enable_reg  <= pwdata[4];
            cks_reg     <= pwdata[1:0];
         end
         presc_reg <= cks_change ? 4'd0 : presc_reg + 4'd1;

         // A pending load is held through the next strobe; re-requests while pending are absorbed.
         if (load_reg) begin
            if (clk_ena) begin
               load_reg <= 1'b0;
            end
         end else if (wr_tcr && pwdata[7]) begin
            load_reg <= 1'b1;
         end

         clr_ovf_reg <= wr_tsr & pwdata[0];
         clr_unf_reg <= wr_tsr & pwdata[1];
      end
   end

   always_comb begin
      rdata = '0;
      case (paddr)
         ADDR_TDR: rdata = tdr_reg;
         ADDR_TCR: begin
            rdata[5]   = up_down_reg;
            rdata[4]   = enable_reg;
            rdata[1:0] = cks_reg;
         end
         ADDR_TSR: begin
            rdata[1] = underflow;
            rdata[0] = overflow;
         end
         default: rdata = tcnt;
      endcase
   end

   assign prdata        = (access && !pwrite) ? rdata : '0;
   assign pready        = access;
   assign pslverr       = access & pwrite & (paddr == ADDR_TCNT);
   assign start_counter = tdr_reg;
   assign up_down       = up_down_reg;
   assign enable        = enable_reg;
   assign load          = load_reg;
   assign clr_overflow  = clr_ovf_reg;
   assign clr_underflow = clr_unf_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed testbench for timer_ctrl: register access, prescaler, load and clear pulses, reset abort.
module tb_timer_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       psel = 1'b0;
   logic       penable = 1'b0;
   logic       pwrite = 1'b0;
   logic [1:0] paddr = 2'd0;
   logic [7:0] pwdata = 8'h00;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;
   logic [7:0] tcnt = 8'h00;
   logic       overflow = 1'b0;
   logic       underflow = 1'b0;
   logic       clk_ena;
   logic [7:0] start_counter;
   logic       up_down;
   logic       enable;
   logic       load;
   logic       clr_overflow;
   logic       clr_underflow;

   int checks = 0;
   int failures = 0;

`ifdef TIMER_CTRL_WAIT_EN
   localparam int EXP_CYC = 4;
`else
   localparam int EXP_CYC = 3;
`endif

   always #5 clk = ~clk;

   timer_ctrl #(.ADDR_W(2), .DATA_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .psel          (psel),
      .penable       (penable),
      .pwrite        (pwrite),
      .paddr         (paddr),
      .pwdata        (pwdata),
      .prdata        (prdata),
      .pready        (pready),
      .pslverr       (pslverr),
      .tcnt          (tcnt),
      .overflow      (overflow),
      .underflow     (underflow),
      .clk_ena       (clk_ena),
      .start_counter (start_counter),
      .up_down       (up_down),
      .enable        (enable),
      .load          (load),
      .clr_overflow  (clr_overflow),
      .clr_underflow (clr_underflow)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // One APB transfer; cycles counts from the master's setup cycle to the cycle with pready=1.
   task automatic apb_xfer(input logic wr, input logic [1:0] addr, input logic [7:0] wdata,
                           output logic [7:0] rdata, output logic err);
      int cyc;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      cyc = 1;
      @(negedge clk);
      penable = 1'b1;
      cyc = 2;
      #1;
      while (!pready && cyc < 8) begin
         @(negedge clk);
         cyc++;
         #1;
      end
      rdata = prdata;
      err   = pslverr;
      check_val("xfer_cycles", cyc, EXP_CYC);
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      $display("xfer %s addr=%0d wdata=0x%02h rdata=0x%02h err=%0b cycles=%0d",
               wr ? "WR" : "RD", addr, wdata, rdata, err, cyc);
   endtask

   // Cycle index (1 = first cycle after the write) of the first clk_ena pulse, 0 if none within limit.
   task automatic first_ena(input int limit, output int pos);
      pos = 0;
      for (int n = 1; n <= limit; n++) begin
         @(negedge clk);
         if (clk_ena && pos == 0) pos = n;
      end
   endtask

   initial begin
      logic [7:0] rd;
      logic       err;
      int         pos;
      int         cnt;
      int         last;
      bit         seen;

      // Reset held for 5 clocks
      repeat (5) @(negedge clk);
      check_val("rst_prdata", prdata, 8'h00);
      check_val("rst_pready", pready, 1'b0);
      check_val("rst_pslverr", pslverr, 1'b0);
      check_val("rst_clk_ena", clk_ena, 1'b0);
      check_val("rst_ctl_outs", {load, clr_overflow, clr_underflow, up_down, enable}, 5'b0);
      check_val("rst_start_counter", start_counter, 8'h00);
      rst_n = 1'b1;

      apb_xfer(1'b0, 2'd0, 8'h00, rd, err); check_val("rd_tdr_rst", rd, 8'h00);
      apb_xfer(1'b0, 2'd1, 8'h00, rd, err); check_val("rd_tcr_rst", rd, 8'h00);
      apb_xfer(1'b0, 2'd2, 8'h00, rd, err); check_val("rd_tsr_rst", rd, 8'h00);

      // TDR / TCR with load, cks=0
      apb_xfer(1'b1, 2'd0, 8'h5A, rd, err);
      check_val("start_counter", start_counter, 8'h5A);
      check_val("wr_tdr_err", err, 1'b0);
      apb_xfer(1'b1, 2'd1, 8'h90, rd, err);
      check_val("enable_set", enable, 1'b1);
      check_val("up_down_clr", up_down, 1'b0);
      seen = 1'b0;
      cnt = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (!load) cnt++;
         if (clk_ena) begin
            check_val("load_at_ena", load, 1'b1);
            @(negedge clk);
            check_val("load_after_ena", load, 1'b0);
            seen = 1'b1;
         end
      end
      check_val("load_held_before_ena", cnt, 0);
      check_val("load_ena_seen", seen, 1'b1);
      apb_xfer(1'b0, 2'd1, 8'h00, rd, err); check_val("rd_tcr_90", rd, 8'h10);
      apb_xfer(1'b0, 2'd0, 8'h00, rd, err); check_val("rd_tdr_5a", rd, 8'h5A);

      // Prescaler cks=1: pulses at cycles 4, 8, 12 after the write
      apb_xfer(1'b1, 2'd1, 8'h11, rd, err);
      cnt = 0; pos = 0; last = 0;
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk);
         if (clk_ena) begin
            cnt++;
            if (pos == 0) pos = n;
            else check_val("cks1_gap", n - last, 4);
            last = n;
         end
      end
      check_val("cks1_first", pos, 4);
      check_val("cks1_count", cnt, 3);
      check_val("cks1_load_idle", load, 1'b0);

      // cks=3: next pulse 16 clk after the write
      apb_xfer(1'b1, 2'd1, 8'h13, rd, err);
      first_ena(20, pos);
      check_val("cks3_first", pos, 16);
      apb_xfer(1'b0, 2'd1, 8'h00, rd, err); check_val("rd_tcr_13", rd, 8'h13);

      // TSR read and W1C pulses
      overflow = 1'b1;
      apb_xfer(1'b0, 2'd2, 8'h00, rd, err); check_val("rd_tsr_ovf", rd, 8'h01);
      apb_xfer(1'b1, 2'd2, 8'h01, rd, err);
      @(negedge clk);
      check_val("clr_ovf_pulse", clr_overflow, 1'b1);
      check_val("clr_unf_quiet", clr_underflow, 1'b0);
      @(negedge clk);
      check_val("clr_ovf_end", clr_overflow, 1'b0);
      underflow = 1'b1;
      apb_xfer(1'b0, 2'd2, 8'h00, rd, err); check_val("rd_tsr_both", rd, 8'h03);
      apb_xfer(1'b1, 2'd2, 8'h03, rd, err);
      @(negedge clk);
      check_val("clr_both_pulse", {clr_underflow, clr_overflow}, 2'b11);
      @(negedge clk);
      check_val("clr_both_end", {clr_underflow, clr_overflow}, 2'b00);
      apb_xfer(1'b1, 2'd2, 8'h00, rd, err);
      @(negedge clk);
      check_val("clr_zero_write", {clr_underflow, clr_overflow}, 2'b00);
      overflow = 1'b0; underflow = 1'b0;

      // TCNT is read-only
      tcnt = 8'hA5;
      apb_xfer(1'b1, 2'd3, 8'h77, rd, err); check_val("tcnt_wr_err", err, 1'b1);
      apb_xfer(1'b0, 2'd3, 8'h00, rd, err);
      check_val("tcnt_rd", rd, 8'hA5);
      check_val("tcnt_rd_err", err, 1'b0);
      apb_xfer(1'b0, 2'd0, 8'h00, rd, err); check_val("tdr_after_tcnt_wr", rd, 8'h5A);

      // Reset during the SETUP cycle of a TCR write
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 2'd1; pwdata = 8'h93;
      @(negedge clk);
      rst_n = 1'b0; penable = 1'b1;
      #1;
      check_val("abort_pready", pready, 1'b0);
      repeat (2) @(negedge clk);
      check_val("abort_outs", {pready, load, enable}, 3'b000);
      rst_n = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      $display("xfer WR addr=1 wdata=0x93 aborted by reset");
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (load || pready) cnt++;
      end
      check_val("abort_no_load", cnt, 0);
      apb_xfer(1'b0, 2'd1, 8'h00, rd, err); check_val("abort_tcr", rd, 8'h00);
      check_val("abort_start_counter", start_counter, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
